// File: rtl/ysyx_23060096_core_seq.sv
// Multi-cycle core sequencer: walks each instruction through fetch, execute,
// optional data-memory access and writeback. It produces the request and
// strobe signals that the datapath and the memories need. Every output is
// decoded from the registered state or taken from a register. No input
// reaches an output combinationally.
module ysyx_23060096_core_seq #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_inst,
    output logic [31:0] ir,
    output logic        dmem_req_valid,
    output logic        dmem_req_we,
    input  logic        dmem_req_ready,
    input  logic        dmem_rsp_valid,
    output logic        pc_we,
    output logic        reg_we_en,
    output logic        halt,
    output logic        err,
    output logic [31:0] instret
);

    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_NOP    = 32'h0000_0013;
    localparam logic [6:0]  OP_LOAD     = 7'b0000011;
    localparam logic [6:0]  OP_STORE    = 7'b0100011;

    // The wait counter only has to reach TIMEOUT-1. That value marks the
    // last allowed cycle in a wait state.
    localparam int          TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_IF_REQ,
        S_IF_WAIT,
        S_EX,
        S_MEM_REQ,
        S_MEM_WAIT,
        S_WB,
        S_HALT,
        S_ERR
    } state_t;

    state_t        state_reg;
    state_t        state_next;
    logic [TW-1:0] tmo_reg;
    logic [31:0]   ir_reg;
    logic [31:0]   instret_reg;

    logic is_load;
    logic is_store;
    logic is_ebreak;
    logic tmo_done;

    assign is_load   = (ir_reg[6:0] == OP_LOAD);
    assign is_store  = (ir_reg[6:0] == OP_STORE);
    assign is_ebreak = (ir_reg == INST_EBREAK);
    assign tmo_done  = (tmo_reg == TMO_LAST);

    // Next-state selection and state-decoded outputs. An exit condition is
    // tested before the timeout, so an exit in the last allowed cycle wins.
    always_comb begin
        state_next     = state_reg;
        imem_req_valid = 1'b0;
        dmem_req_valid = 1'b0;
        dmem_req_we    = 1'b0;
        pc_we          = 1'b0;
        reg_we_en      = 1'b0;
        halt           = 1'b0;
        err            = 1'b0;
        unique case (state_reg)
            S_IDLE: begin
                state_next = S_IF_REQ;
            end
            S_IF_REQ: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) begin
                    state_next = S_IF_WAIT;
                end else if (tmo_done) begin
                    state_next = S_ERR;
                end
            end
            S_IF_WAIT: begin
                if (imem_rsp_valid) begin
                    state_next = S_EX;
                end else if (tmo_done) begin
                    state_next = S_ERR;
                end
            end
            S_EX: begin
                if (is_ebreak) begin
                    state_next = S_HALT;
                end else if (is_load || is_store) begin
                    state_next = S_MEM_REQ;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM_REQ: begin
                dmem_req_valid = 1'b1;
                dmem_req_we    = is_store;
                if (dmem_req_ready) begin
                    state_next = S_MEM_WAIT;
                end else if (tmo_done) begin
                    state_next = S_ERR;
                end
            end
            S_MEM_WAIT: begin
                if (dmem_rsp_valid) begin
                    state_next = S_WB;
                end else if (tmo_done) begin
                    state_next = S_ERR;
                end
            end
            S_WB: begin
                pc_we      = 1'b1;
                reg_we_en  = ~is_store;
                state_next = S_IF_REQ;
            end
            S_HALT: begin
                halt = 1'b1;
            end
            S_ERR: begin
                err = 1'b1;
            end
            default: begin
                state_next = S_ERR;
            end
        endcase
    end

    // State register. HALT and ERR have no exit, so only reset leaves them.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // The wait counter restarts on every state change. Inside a state it
    // saturates, so it does not toggle in the terminal states.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            tmo_reg <= '0;
        end else if (state_next != state_reg) begin
            tmo_reg <= '0;
        end else if (!tmo_done) begin
            tmo_reg <= tmo_reg + 1'b1;
        end
    end

    // The instruction register captures the fetch response only in IF_WAIT.
    // A stray response in any other state is dropped.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            ir_reg <= INST_NOP;
        end else if (state_reg == S_IF_WAIT && imem_rsp_valid) begin
            ir_reg <= imem_rsp_inst;
        end
    end

    // The retire count advances once per writeback and once when ebreak
    // enters HALT. It wraps silently.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            instret_reg <= '0;
        end else if (state_reg == S_WB || (state_reg == S_EX && is_ebreak)) begin
            instret_reg <= instret_reg + 32'd1;
        end
    end

    assign ir      = ir_reg;
    assign instret = instret_reg;

endmodule

// File: tb/tb_ysyx_23060096_core_seq.sv
// Randomized bench for the core sequencer. Each instruction is described by
// its handshake delays. The delays expand into a per-cycle schedule of
// memory inputs and the outputs those cycles must show. A single loop drives
// the schedule and compares every cycle.
module tb_ysyx_23060096_core_seq;

    localparam int          TO     = 8;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] ADDI   = 32'h0010_0093;
    localparam logic [31:0] LOAD   = 32'h0000_2103;
    localparam logic [31:0] STORE  = 32'h0020_2023;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_inst = '0;
    logic        dmem_req_ready = 1'b0;
    logic        dmem_rsp_valid = 1'b0;
    logic        imem_req_valid, dmem_req_valid, dmem_req_we;
    logic        pc_we, reg_we_en, halt, err;
    logic [31:0] ir, instret;

    always #5 clk = ~clk;

    ysyx_23060096_core_seq #(.TIMEOUT(TO)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_inst  (imem_rsp_inst),
        .ir             (ir),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_we    (dmem_req_we),
        .dmem_req_ready (dmem_req_ready),
        .dmem_rsp_valid (dmem_rsp_valid),
        .pc_we          (pc_we),
        .reg_we_en      (reg_we_en),
        .halt           (halt),
        .err            (err),
        .instret        (instret)
    );

    typedef struct {
        logic        iready, irsp, dready, drsp;
        logic [31:0] iinst;
        logic        ireq, dreq, dwe, pcwe, regwe, hlt, er;
        logic [31:0] exp_ir, exp_instret;
    } cyc_t;

    cyc_t        q[$];
    logic [31:0] m_ir;
    logic [31:0] m_instret;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc_no = 0;
    int          first_ireq, first_pcwe, pcwe_cnt, regwe_cnt, dreq_cnt, dwe_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc_no, act, exp);
        end
    endtask

    // A cycle with random, don't-care memory inputs and all strobes low.
    function automatic cyc_t blank();
        cyc_t e;
        e.iready = 1'($urandom);
        e.irsp   = 1'($urandom);
        e.dready = 1'($urandom);
        e.drsp   = 1'($urandom);
        e.iinst  = $urandom;
        e.ireq = 0; e.dreq = 0; e.dwe = 0; e.pcwe = 0; e.regwe = 0; e.hlt = 0; e.er = 0;
        e.exp_ir      = m_ir;
        e.exp_instret = m_instret;
        return e;
    endfunction

    task automatic push_term(input int n, input bit is_err);
        cyc_t e;
        repeat (n) begin
            e = blank();
            if (is_err) e.er = 1; else e.hlt = 1;
            q.push_back(e);
        end
    endtask

    // Expands one instruction into its cycles. a/b: imem ready and response
    // delays. c/d: dmem ready and response delays. A delay of TO or more
    // means the handshake never completes. cut stops in MEM_WAIT before the
    // response arrives.
    task automatic gen_instr(input logic [31:0] inst, input int a, input int b,
                             input int c, input int d, input bit cut);
        cyc_t e;
        bit   st, mem;
        for (int i = 0; i <= a && i < TO; i++) begin
            e = blank(); e.ireq = 1; e.iready = (i == a); q.push_back(e);
        end
        if (a >= TO) begin push_term(6, 1); return; end
        for (int i = 0; i <= b && i < TO; i++) begin
            e = blank(); e.irsp = (i == b);
            if (i == b) e.iinst = inst;
            q.push_back(e);
        end
        if (b >= TO) begin push_term(6, 1); return; end
        m_ir = inst;
        e = blank(); q.push_back(e);                 // execute
        if (inst == EBREAK) begin
            m_instret = m_instret + 1;
            push_term(20, 0);
            return;
        end
        st  = (inst[6:0] == 7'b0100011);
        mem = st || (inst[6:0] == 7'b0000011);
        if (mem) begin
            for (int i = 0; i <= c && i < TO; i++) begin
                e = blank(); e.dreq = 1; e.dwe = st; e.dready = (i == c); q.push_back(e);
            end
            if (c >= TO) begin push_term(6, 1); return; end
            for (int i = 0; i <= d && i < TO; i++) begin
                if (cut && i == d) return;
                e = blank(); e.drsp = (i == d); q.push_back(e);
            end
            if (d >= TO) begin push_term(6, 1); return; end
        end
        e = blank(); e.pcwe = 1; e.regwe = !st; q.push_back(e);
        m_instret = m_instret + 1;
    endtask

    task automatic clear_stats();
        first_ireq = -1; first_pcwe = -1;
        pcwe_cnt = 0; regwe_cnt = 0; dreq_cnt = 0; dwe_cnt = 0;
    endtask

    // Drives each scheduled cycle and compares the outputs at mid-cycle.
    task automatic run_queue();
        cyc_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            @(posedge clk); #1;
            rstn           = 1'b0;
            imem_req_ready = e.iready;
            imem_rsp_valid = e.irsp;
            imem_rsp_inst  = e.iinst;
            dmem_req_ready = e.dready;
            dmem_rsp_valid = e.drsp;
            @(negedge clk);
            cyc_no++;
            chk("ctl", {25'd0, imem_req_valid, dmem_req_valid, dmem_req_we, pc_we, reg_we_en, halt, err},
                       {25'd0, e.ireq, e.dreq, e.dwe, e.pcwe, e.regwe, e.hlt, e.er});
            chk("ir", ir, e.exp_ir);
            chk("instret", instret, e.exp_instret);
            if (imem_req_valid && first_ireq < 0) first_ireq = cyc_no;
            if (pc_we && first_pcwe < 0) first_pcwe = cyc_no;
            if (pc_we) pcwe_cnt++;
            if (reg_we_en) regwe_cnt++;
            if (dmem_req_valid) dreq_cnt++;
            if (dmem_req_we) dwe_cnt++;
        end
    endtask

    // Asserts reset between clock edges with stale responses on the bus and
    // checks that the outputs reset at once. The release and the IDLE cycle
    // are the first scheduled entry.
    task automatic do_reset();
        cyc_t e;
        @(posedge clk); #3;
        rstn = 1'b1;
        imem_rsp_valid = 1'b1; dmem_rsp_valid = 1'b1; imem_rsp_inst = $urandom;
        #1;
        chk("rst_ir", ir, NOP);
        chk("rst_instret", instret, 32'd0);
        chk("rst_outs", {25'd0, imem_req_valid, dmem_req_valid, dmem_req_we, pc_we, reg_we_en, halt, err}, 32'd0);
        repeat (2) @(posedge clk);
        q.delete();
        m_ir = NOP;
        m_instret = 0;
        clear_stats();
        e = blank(); e.irsp = 1; e.drsp = 1; q.push_back(e);
    endtask

    function automatic int rd();
        return ($urandom_range(9, 0) == 0) ? 7 : int'($urandom_range(3, 0));
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(6, 0))
            0: v[6:0] = 7'b0000011;
            1: v[6:0] = 7'b0100011;
            2: v[6:0] = 7'b0110011;
            3: v[6:0] = 7'b0110111;
            4: v[6:0] = 7'b1100011;
            default: v[6:0] = 7'b0010011;
        endcase
        return v;
    endfunction

    initial begin
        // Zero-wait addi: WB is the fourth cycle counted from the first IF_REQ.
        do_reset();
        gen_instr(ADDI, 0, 0, 0, 0, 0);
        run_queue();
        chk("addi_wb_offset", 32'(first_pcwe - first_ireq), 32'd3);
        chk("addi_pcwe_cnt", 32'(pcwe_cnt), 32'd1);
        chk("addi_ir", ir, ADDI);
        @(posedge clk); #1;
        chk("addi_instret", instret, 32'd1);

        // Load whose ready comes 3 cycles late keeps the request up 4 cycles.
        do_reset();
        gen_instr(LOAD, 0, 0, 3, 1, 0);
        run_queue();
        chk("load_dreq_cycles", 32'(dreq_cnt), 32'd4);
        chk("load_dwe_cycles", 32'(dwe_cnt), 32'd0);
        chk("load_regwe", 32'(regwe_cnt), 32'd1);

        // A store writes the PC but not the register file.
        do_reset();
        gen_instr(STORE, 1, 0, 1, 2, 0);
        run_queue();
        chk("store_dwe_cycles", 32'(dwe_cnt), 32'd2);
        chk("store_pcwe", 32'(pcwe_cnt), 32'd1);
        chk("store_regwe", 32'(regwe_cnt), 32'd0);

        // Three addi then ebreak: the core halts with four retired.
        do_reset();
        repeat (3) gen_instr(ADDI, rd(), rd(), 0, 0, 0);
        gen_instr(EBREAK, rd(), rd(), 0, 0, 0);
        run_queue();
        chk("halt_flag", 32'(halt), 32'd1);
        chk("halt_instret", instret, 32'd4);

        // Fetch request never accepted: error after TO cycles, ir unchanged.
        do_reset();
        gen_instr(ADDI, TO, 0, 0, 0, 0);
        run_queue();
        chk("tmo_err", 32'(err), 32'd1);
        chk("tmo_ir", ir, NOP);

        // Fetch accepted in the last allowed cycle: no error.
        do_reset();
        gen_instr(ADDI, TO - 1, TO - 1, 0, 0, 0);
        run_queue();
        chk("edge_no_err", 32'(err), 32'd0);

        // Timeouts in the fetch-response and data-response waits.
        do_reset();
        gen_instr(ADDI, 0, TO, 0, 0, 0);
        run_queue();
        do_reset();
        gen_instr(STORE, 0, 0, 0, TO, 0);
        run_queue();

        // Reset during MEM_WAIT, stale response after release, fresh restart.
        do_reset();
        gen_instr(LOAD, 0, 0, 0, 3, 1);
        run_queue();
        do_reset();
        gen_instr(ADDI, 0, 1, 0, 0, 0);
        run_queue();
        chk("restart_first_ireq", 32'(first_ireq - cyc_no), 32'(-4));

        // Randomized instruction streams ending in ebreak.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int k = 0; k < 12; k++) gen_instr(rand_inst(), rd(), rd(), rd(), rd(), 0);
            gen_instr(EBREAK, rd(), rd(), 0, 0, 0);
            run_queue();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
